// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer. Optional macro DEBOUNCE_TOGGLE_EN
// (used by the top level) selects click-toggle LEDs instead of level-follow LEDs.
package debounce_pkg;

  localparam int NUM_SWITCHES           = 4;
  localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;

  // The counter must hold DEBOUNCE_LIMIT-1. One spare code keeps LIMIT=1 at one bit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_switches_if.sv
// Board-side signal bundle of the debouncer: raw switch pins in, LEDs and
// conditioned switch levels/events out.
interface debounce_switches_if;
  import debounce_pkg::*;

  logic                    i_switch_1;
  logic                    i_switch_2;
  logic                    i_switch_3;
  logic                    i_switch_4;
  logic                    o_led_1;
  logic                    o_led_2;
  logic                    o_led_3;
  logic                    o_led_4;
  logic [NUM_SWITCHES-1:0] o_switch;
  logic [NUM_SWITCHES-1:0] o_press;
  logic [NUM_SWITCHES-1:0] o_release;

  // Board / stimulus side.
  modport master (
    output i_switch_1, i_switch_2, i_switch_3, i_switch_4,
    input  o_led_1, o_led_2, o_led_3, o_led_4,
    input  o_switch, o_press, o_release
  );

  // Debouncer side.
  modport slave (
    input  i_switch_1, i_switch_2, i_switch_3, i_switch_4,
    output o_led_1, o_led_2, o_led_3, o_led_4,
    output o_switch, o_press, o_release
  );

endinterface

// File: rtl/debounce_filter.sv
// One debounce channel: 2-flop synchroniser, stability counter, stable bit and
// registered one-cycle press/release pulses.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press,
  output logic o_release
);

  localparam int            CW   = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic          r_release;
  logic [CW-1:0] r_count;

  logic w_differ;
  logic w_commit;

  assign w_differ = (r_sync2 != r_stable);
  assign w_commit = w_differ && (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments are what make r_sync1/r_sync2 two real
      // pipeline stages; blocking ones would collapse them into a single flop.
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_press   <= w_commit &&  r_sync2;
      r_release <= w_commit && !r_sync2;
      // Any agreeing sample restarts the count, so short bounces never commit.
      if (!w_differ || w_commit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
      if (w_commit) begin
        r_stable <= r_sync2;
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/debounce_switches.sv
// Four independent debounce channels driving the board LEDs. Define
// DEBOUNCE_TOGGLE_EN for click-toggle LEDs; otherwise LEDs show the debounced level.
module debounce_switches
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  debounce_switches_if.slave  bus
);

  logic [NUM_SWITCHES-1:0] w_raw;
  logic [NUM_SWITCHES-1:0] w_stable;
  logic [NUM_SWITCHES-1:0] w_press;
  logic [NUM_SWITCHES-1:0] w_release;
  logic [NUM_SWITCHES-1:0] w_led;

  assign w_raw = {bus.i_switch_4, bus.i_switch_3, bus.i_switch_2, bus.i_switch_1};

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
    debounce_filter #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_filter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (w_raw[g]),
      .o_stable  (w_stable[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic [NUM_SWITCHES-1:0] r_led;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led <= '0;
    end else begin
      r_led <= r_led ^ w_release;
    end
  end

  // XOR with the live pulse lets the LED flip on the same edge as o_release;
  // r_led absorbs the flip one edge later, when the pulse has dropped.
  assign w_led = r_led ^ w_release;
`else
  assign w_led = w_stable;
`endif

  assign bus.o_switch  = w_stable;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;
  assign bus.o_led_1   = w_led[0];
  assign bus.o_led_2   = w_led[1];
  assign bus.o_led_3   = w_led[2];
  assign bus.o_led_4   = w_led[3];

endmodule

// File: tb/tb_debounce_switches.sv
// Directed bench for debounce_switches with DEBOUNCE_LIMIT = 4: reset, clean
// press/release, sub-limit bounce, LED behaviour, mid-count reset, all-channel change.
module tb_debounce_switches;
  import debounce_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [3:0] exp_sw;
  logic [3:0] exp_tog;

  always #5 clk = ~clk;

  debounce_switches_if u_if ();

  debounce_switches #(
    .DEBOUNCE_LIMIT (LIMIT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    u_if.i_switch_1 = v[0];
    u_if.i_switch_2 = v[1];
    u_if.i_switch_3 = v[2];
    u_if.i_switch_4 = v[3];
  endtask

  // One rising edge, then park on the falling edge to sample and drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] led_now();
    return {u_if.o_led_4, u_if.o_led_3, u_if.o_led_2, u_if.o_led_1};
  endfunction

  function automatic logic [3:0] exp_led();
`ifdef DEBOUNCE_TOGGLE_EN
    return exp_tog;
`else
    return exp_sw;
`endif
  endfunction

  // Run n edges; on edge 'hit' (0 = never) the channels in 'mask' are expected
  // to commit a rise (rise=1) or fall (rise=0). Every edge checks all outputs.
  task automatic watch(input string tag, input int n, input int hit,
                       input logic [3:0] mask, input bit rise);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == hit) begin
        if (rise) begin
          exp_sw = exp_sw | mask;
        end else begin
          exp_sw  = exp_sw & ~mask;
          exp_tog = exp_tog ^ mask;
        end
      end
      check({tag, "/press"},   u_if.o_press,   (i == hit &&  rise) ? mask : 4'b0000);
      check({tag, "/release"}, u_if.o_release, (i == hit && !rise) ? mask : 4'b0000);
      check({tag, "/switch"},  u_if.o_switch,  exp_sw);
      check({tag, "/led"},     led_now(),      exp_led());
    end
  endtask

  task automatic reset_cycles(input string tag, input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "/press"},   u_if.o_press,   4'b0000);
      check({tag, "/release"}, u_if.o_release, 4'b0000);
      check({tag, "/switch"},  u_if.o_switch,  4'b0000);
      check({tag, "/led"},     led_now(),      4'b0000);
    end
    exp_sw  = 4'b0000;
    exp_tog = 4'b0000;
    rst     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_sw   = 4'b0000;
    exp_tog  = 4'b0000;
    rst      = 1'b1;
    set_sw(4'b1111);
    @(negedge clk);

    // Switches held through reset are seen as a fresh press 6 edges later.
    reset_cycles("reset", 3);
    watch("rst_press", 8, 6, 4'b1111, 1'b1);
    set_sw(4'b0000);
    watch("rst_release", 8, 6, 4'b1111, 1'b0);
    reset_cycles("reset2", 1);

    // Clean press and release of switch 1.
    set_sw(4'b0001);
    watch("press1", 8, 6, 4'b0001, 1'b1);
    set_sw(4'b0000);
    watch("release1", 8, 6, 4'b0001, 1'b0);

    // Switch 2 bounce: high 3, low 1, high 3, low -- never reaches the limit.
    set_sw(4'b0010);
    watch("bounce_a", 3, 0, 4'b0000, 1'b1);
    set_sw(4'b0000);
    watch("bounce_b", 1, 0, 4'b0000, 1'b1);
    set_sw(4'b0010);
    watch("bounce_c", 3, 0, 4'b0000, 1'b1);
    set_sw(4'b0000);
    watch("bounce_d", 8, 0, 4'b0000, 1'b1);

    // Switch 3 held 20 cycles, dropped, then a second click.
    set_sw(4'b0100);
    watch("hold3", 20, 6, 4'b0100, 1'b1);
    set_sw(4'b0000);
    watch("drop3", 8, 6, 4'b0100, 1'b0);
    set_sw(4'b0100);
    watch("hold3b", 10, 6, 4'b0100, 1'b1);
    set_sw(4'b0000);
    watch("drop3b", 8, 6, 4'b0100, 1'b0);

    // Switch 4 reset mid-count: no pulse, full latency restarts after reset.
    set_sw(4'b1000);
    watch("mid_pre", 3, 0, 4'b0000, 1'b1);
    reset_cycles("mid_reset", 1);
    watch("mid_post", 8, 6, 4'b1000, 1'b1);
    set_sw(4'b0000);
    watch("mid_release", 8, 6, 4'b1000, 1'b0);

    // All four channels change on the same edge.
    set_sw(4'b1111);
    watch("simul_press", 8, 6, 4'b1111, 1'b1);
    set_sw(4'b0000);
    watch("simul_release", 8, 6, 4'b1111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
